floo_serial_link_vc_mux: RTL and testbench

//  Upstream stage of the floo serial link wrapper. Merges the req and rsp flit

---
 rtl/floo_serial_link_vc_mux.sv | 117 +++++++++++
 tb/tb_floo_serial_link_vc_mux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/floo_serial_link_vc_mux.sv
// Merges req/rsp flits into one VC-tagged stream with per-VC credits and round-robin arbitration.
// Latency 1 cycle, output held under !ready_i, no input accepted then; FLOO_SL_VC_MUX_STALL_CNT_EN adds stall counters.
module floo_serial_link_vc_mux #(
   parameter int unsigned ReqWidth   = 64,
   parameter int unsigned RspWidth   = 64,
   parameter int unsigned NumCredits = 8,
   parameter int unsigned DataWidth  = (ReqWidth > RspWidth) ? ReqWidth : RspWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [ReqWidth-1:0]  req_data_i,
   input  logic                 rsp_valid_i,
   output logic                 rsp_ready_o,
   input  logic [RspWidth-1:0]  rsp_data_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 vc_o,
   input  logic                 credit_valid_i,
   input  logic                 credit_vc_i,
   output logic                 credit_err_o,
   output logic [1:0][15:0]     stall_cnt_o
);
   localparam int unsigned CntWidth = $clog2(NumCredits + 1);
   localparam logic [CntWidth-1:0] CreditMax = CntWidth'(NumCredits);

   typedef struct packed {
      logic                 vc;
      logic [DataWidth-1:0] data;
   } flit_t;

   logic [1:0][CntWidth-1:0] credits_q;
   logic [1:0]               flit_valid;
   logic [1:0]               elig;
   logic [1:0]               grant;
   logic [1:0]               credit_ret;
   logic                     load_en;
   logic                     prio_q;
   flit_t                    flit_in;
   flit_t                    out_q;

   assign flit_valid = {rsp_valid_i, req_valid_i};
   assign load_en    = !valid_o || ready_i;

   always_comb begin
      for (int v = 0; v < 2; v++) begin
         elig[v]       = flit_valid[v] && (credits_q[v] != '0);
         credit_ret[v] = credit_valid_i && (credit_vc_i == 1'(v));
      end
   end

   // prio_q names the VC that wins a tie; it always points away from the last grant.
   always_comb begin
      grant = '0;
      if (load_en) begin
         if (&elig) grant[prio_q] = 1'b1;
         else       grant = elig;
      end
   end

   assign req_ready_o  = grant[0];
   assign rsp_ready_o  = grant[1];
   assign flit_in.vc   = grant[1];
   assign flit_in.data = grant[1] ? DataWidth'(rsp_data_i) : DataWidth'(req_data_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         out_q   <= '0;
         prio_q  <= 1'b0;
      end else if (load_en) begin
         valid_o <= |grant;
         if (|grant) begin
            out_q  <= flit_in;
            prio_q <= ~grant[1];
         end
      end
   end

   assign data_o = out_q.data;
   assign vc_o   = out_q.vc;

   // Credits are consumed at the input handshake so a held output flit already owns its slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credits_q    <= {2{CreditMax}};
         credit_err_o <= 1'b0;
      end else begin
         for (int v = 0; v < 2; v++) begin
            if (grant[v] && !credit_ret[v]) begin
               credits_q[v] <= credits_q[v] - 1'b1;
            end else if (credit_ret[v] && !grant[v]) begin
               if (credits_q[v] == CreditMax) credit_err_o <= 1'b1;
               else                           credits_q[v] <= credits_q[v] + 1'b1;
            end
         end
      end
   end

`ifdef FLOO_SL_VC_MUX_STALL_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_o <= '0;
      end else begin
         for (int v = 0; v < 2; v++) begin
            if (flit_valid[v] && (credits_q[v] == '0) && (stall_cnt_o[v] != 16'hFFFF))
               stall_cnt_o[v] <= stall_cnt_o[v] + 16'd1;
         end
      end
   end
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_floo_serial_link_vc_mux.sv
// Scoreboard bench for floo_serial_link_vc_mux: a credit/round-robin reference model predicts
// input grants and pushes expected flits; a negedge monitor pops and checks the output stream.
module tb_floo_serial_link_vc_mux;
   localparam int NC = 8;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             req_valid_i = 1'b0;
   logic             req_ready_o;
   logic [63:0]      req_data_i = '0;
   logic             rsp_valid_i = 1'b0;
   logic             rsp_ready_o;
   logic [63:0]      rsp_data_i = '0;
   logic             valid_o;
   logic             ready_i = 1'b0;
   logic [63:0]      data_o;
   logic             vc_o;
   logic             credit_valid_i = 1'b0;
   logic             credit_vc_i = 1'b0;
   logic             credit_err_o;
   logic [1:0][15:0] stall_cnt_o;

   floo_serial_link_vc_mux #(.ReqWidth(64), .RspWidth(64), .NumCredits(NC)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
      .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_data_i(rsp_data_i),
      .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .vc_o(vc_o),
      .credit_valid_i(credit_valid_i), .credit_vc_i(credit_vc_i),
      .credit_err_o(credit_err_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        vc;
      logic [63:0] data;
   } exp_t;

`ifdef FLOO_SL_VC_MUX_STALL_CNT_EN
   localparam int StallExp = 10;
`else
   localparam int StallExp = 0;
`endif

   exp_t sb_q[$];
   exp_t pend;
   bit   pend_vld;
   int   total, bad;
   int   m_cred[2];
   int   m_tie;
   bit   m_err;
   int   m_stall[2];
   int   obs_hs[2];
   int   obs_vc[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: output register must mirror the scoreboard head.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         chk("valid_o", valid_o, sb_q.size() != 0);
         if (valid_o && sb_q.size() != 0) begin
            chk("vc_o", vc_o, sb_q[0].vc);
            chk("data_o", data_o, sb_q[0].data);
            if (ready_i) void'(sb_q.pop_front());
         end
      end
   end

   task automatic step(input bit rv, input bit sv, input bit rdy, input bit cv, input bit cvc);
      int          g;
      bit          le, e0, e1;
      logic [63:0] rd, sd;
      rd = {$urandom, $urandom};
      sd = {$urandom, $urandom};
      @(posedge clk_i);
      #1;
      if (pend_vld) begin
         sb_q.push_back(pend);
         pend_vld = 1'b0;
      end
      req_valid_i = rv; req_data_i = rd;
      rsp_valid_i = sv; rsp_data_i = sd;
      ready_i = rdy;
      credit_valid_i = cv; credit_vc_i = cvc;
      #1;
      le = (sb_q.size() == 0) || rdy;
      e0 = rv && m_cred[0] > 0;
      e1 = sv && m_cred[1] > 0;
      g = -1;
      if (le) begin
         if (e0 && e1)  g = m_tie;
         else if (e0)   g = 0;
         else if (e1)   g = 1;
      end
      chk("req_ready_o", req_ready_o, g == 0);
      chk("rsp_ready_o", rsp_ready_o, g == 1);
      chk("credit_err_o", credit_err_o, m_err);
      chk("stall_cnt0", stall_cnt_o[0], m_stall[0]);
      chk("stall_cnt1", stall_cnt_o[1], m_stall[1]);
      if (req_ready_o && rv) begin obs_hs[0]++; obs_vc.push_back(0); end
      if (rsp_ready_o && sv) begin obs_hs[1]++; obs_vc.push_back(1); end
`ifdef FLOO_SL_VC_MUX_STALL_CNT_EN
      if (rv && m_cred[0] == 0 && m_stall[0] < 65535) m_stall[0]++;
      if (sv && m_cred[1] == 0 && m_stall[1] < 65535) m_stall[1]++;
`endif
      if (g >= 0) begin
         pend.vc   = (g == 1);
         pend.data = (g == 1) ? sd : rd;
         pend_vld  = 1'b1;
         m_cred[g]--;
         m_tie = 1 - g;
      end
      if (cv) begin
         if (m_cred[cvc] == NC) m_err = 1'b1;
         else                   m_cred[cvc]++;
      end
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #3;
      rst_ni = 1'b0;
      req_valid_i = 0; rsp_valid_i = 0; ready_i = 0; credit_valid_i = 0; credit_vc_i = 0;
      #1;
      chk("rst_valid_o", valid_o, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_vc_o", vc_o, 0);
      chk("rst_credit_err_o", credit_err_o, 0);
      chk("rst_stall_cnt_o", stall_cnt_o, 0);
      sb_q.delete();
      pend_vld = 1'b0;
      m_cred[0] = NC; m_cred[1] = NC;
      m_tie = 0; m_err = 1'b0;
      m_stall[0] = 0; m_stall[1] = 0;
      repeat (2) @(posedge clk_i);
      #3;
      rst_ni = 1'b1;
   endtask

   initial begin
      int base;
      total = 0; bad = 0;
      obs_hs[0] = 0; obs_hs[1] = 0;

      // 1: credit limit on a single VC
      do_reset();
      base = obs_hs[0];
      repeat (12) step(1, 0, 1, 0, 0);
      chk("t1_req_grants", obs_hs[0] - base, 8);

      // 2: alternation, req first after reset
      do_reset();
      obs_vc.delete();
      repeat (6) step(1, 1, 1, 0, 0);
      chk("t2_grant_count", obs_vc.size(), 6);
      for (int i = 0; i < obs_vc.size(); i++) chk("t2_vc_order", obs_vc[i], i % 2);

      // 3: backpressure hold then release
      do_reset();
      step(1, 0, 1, 0, 0);
      base = obs_hs[0];
      repeat (5) step(1, 0, 0, 0, 0);
      chk("t3_no_accept", obs_hs[0] - base, 0);
      repeat (3) step(1, 0, 1, 0, 0);

      // 4: req out of credits, rsp still flows; one credit -> one req flit
      do_reset();
      repeat (8) step(1, 0, 1, 0, 0);
      base = obs_hs[1];
      repeat (4) step(1, 1, 1, 0, 0);
      chk("t4_rsp_flow", obs_hs[1] - base, 4);
      step(1, 1, 1, 1, 0);
      base = obs_hs[0];
      repeat (3) step(1, 1, 1, 0, 0);
      chk("t4_one_req", obs_hs[0] - base, 1);

      // 5: simultaneous grant+return, then overflow error
      do_reset();
      repeat (5) step(1, 0, 1, 0, 0);
      step(1, 0, 1, 1, 0);
      base = obs_hs[0];
      repeat (6) step(1, 0, 1, 0, 0);
      chk("t5_net_three", obs_hs[0] - base, 3);
      repeat (9) step(0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 0);
      chk("t5_credit_err", credit_err_o, 1);
      base = obs_hs[0];
      repeat (10) step(1, 0, 1, 0, 0);
      chk("t5_saturated_eight", obs_hs[0] - base, 8);

      // 6: starvation counter on VC1
      do_reset();
      repeat (8) step(0, 1, 1, 0, 0);
      repeat (10) step(0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("t6_stall_vc1", stall_cnt_o[1], StallExp);
      chk("t6_stall_vc0", stall_cnt_o[0], 0);

      // mid-burst reset restores credits
      repeat (3) step(1, 1, 1, 0, 0);
      do_reset();
      base = obs_hs[0];
      repeat (10) step(1, 0, 1, 0, 0);
      chk("t6_credits_restored", obs_hs[0] - base, 8);

      // random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bit cv, cvc;
         cvc = 1'($urandom_range(0, 1));
         cv  = ($urandom_range(0, 2) != 0) && (m_cred[cvc] < NC);
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, cv, cvc);
      end
      repeat (3) step(0, 0, 1, 0, 0);
      chk("drain_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
